// File: rtl/eic_irq_scheduler_if.sv
// Register port and core-side EIC handshake of the interrupt scheduler.
// master = software/core side, slave = the scheduler.
interface eic_irq_scheduler_if;
    logic [2:0]  reg_addr;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        SI_IAck;
    logic [5:0]  SI_IVN;
    logic        SI_EICPresent;
    logic [7:0]  SI_Int;
    logic [5:0]  SI_EICVector;
    logic [16:0] SI_Offset;
    logic [3:0]  SI_EISS;

    modport master (
        output reg_addr, reg_we, reg_wdata, SI_IAck, SI_IVN,
        input  reg_rdata, SI_EICPresent, SI_Int, SI_EICVector, SI_Offset, SI_EISS
    );

    modport slave (
        input  reg_addr, reg_we, reg_wdata, SI_IAck, SI_IVN,
        output reg_rdata, SI_EICPresent, SI_Int, SI_EICVector, SI_Offset, SI_EISS
    );
endinterface

// File: rtl/eic_irq_scheduler.sv
// External interrupt controller for a MIPS core in EIC mode: synchronises IRQ lines,
// latches edge/level events and presents the highest-priority unmasked line as RIPL/vector.
module eic_irq_scheduler #(
    parameter int          NUM_IRQ     = 8,
    parameter logic [16:0] OFFSET_BASE = 17'h100,
    parameter logic [16:0] OFFSET_STEP = 17'h10
) (
    input  logic               SI_ClkIn,
    input  logic               SI_Reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    eic_irq_scheduler_if.slave bus
);
    localparam logic [2:0] REG_MASK    = 3'd0;
    localparam logic [2:0] REG_SENSE   = 3'd1;
    localparam logic [2:0] REG_PENDING = 3'd2;
    localparam logic [2:0] REG_RAW     = 3'd3;
    localparam logic [2:0] REG_ACTIVE  = 3'd4;

    logic [NUM_IRQ-1:0] sync1_q, sync_q, prev_q;
    logic [NUM_IRQ-1:0] mask_q, mask_d, sense_q, sense_d, pending_q, pending_d;
    logic [NUM_IRQ-1:0] ack_hit, clr, rise, cand, wdata_irq;
    logic [5:0]         vec_q, vec_d;
    logic [16:0]        offset_q, offset_d;
    logic               unused_wdata;

    assign wdata_irq    = bus.reg_wdata[NUM_IRQ-1:0];
    assign unused_wdata = ^bus.reg_wdata;

    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        mask_d  = mask_q;
        sense_d = sense_q;
        if (bus.reg_we && bus.reg_addr == REG_MASK)  mask_d  = wdata_irq;
        if (bus.reg_we && bus.reg_addr == REG_SENSE) sense_d = wdata_irq;

        ack_hit = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_hit[i] = bus.SI_IAck && (bus.SI_IVN == 6'(i + 1));
        end
        clr  = ack_hit | ((bus.reg_we && bus.reg_addr == REG_PENDING) ? wdata_irq : '0);
        rise = sync_q & ~prev_q;
        // A rising edge is OR-ed in after the clear, so it wins over a coincident clear.
        pending_d = (sense_q & ((pending_q & ~clr) | rise)) | (~sense_q & sync_q);

        // An edge line being acknowledged this cycle must not be re-presented.
        cand  = pending_q & mask_q & ~(ack_hit & sense_q);
        vec_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (cand[i]) vec_d = 6'(i + 1);
        end
        offset_d = OFFSET_BASE + 17'(vec_d) * OFFSET_STEP;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous so it sits inside the clocked branch.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            sync1_q   <= '0;
            sync_q    <= '0;
            prev_q    <= '0;
            mask_q    <= '0;
            sense_q   <= '0;
            pending_q <= '0;
            vec_q     <= '0;
            offset_q  <= '0;
        end else begin
            sync1_q   <= irq_in;
            sync_q    <= sync1_q;
            prev_q    <= sync_q;
            mask_q    <= mask_d;
            sense_q   <= sense_d;
            pending_q <= pending_d;
            vec_q     <= vec_d;
            offset_q  <= offset_d;
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_addr)
            REG_MASK:    bus.reg_rdata = 32'(mask_q);
            REG_SENSE:   bus.reg_rdata = 32'(sense_q);
            REG_PENDING: bus.reg_rdata = 32'(pending_q);
            REG_RAW:     bus.reg_rdata = 32'(sync_q);
            REG_ACTIVE:  bus.reg_rdata = 32'(vec_q);
            default:     bus.reg_rdata = '0;
        endcase
    end

    assign bus.SI_EICPresent = 1'b1;
    assign bus.SI_EISS       = 4'd0;
    assign bus.SI_Int        = {2'b00, vec_q};
    assign bus.SI_EICVector  = vec_q;
    assign bus.SI_Offset     = offset_q;

endmodule

// File: tb/tb_eic_irq_scheduler.sv
// Directed self-checking bench for eic_irq_scheduler (NUM_IRQ=8, default offsets).
module tb_eic_irq_scheduler;
    logic       clk;
    logic       rst;
    logic [7:0] irq;
    int         checks;
    int         failures;

    eic_irq_scheduler_if bus ();

    eic_irq_scheduler #(.NUM_IRQ(8), .OFFSET_BASE(17'h100), .OFFSET_STEP(17'h10)) dut (
        .SI_ClkIn (clk),
        .SI_Reset (rst),
        .irq_in   (irq),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are observed there too.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
        bus.reg_addr  = addr;
        bus.reg_wdata = data;
        bus.reg_we    = 1'b1;
        tick();
        bus.reg_we    = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] addr, output logic [31:0] data);
        bus.reg_addr = addr;
        #1;
        data = bus.reg_rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        tick(2);
        checks++;
        if (bus.SI_Int !== 8'd0 || bus.SI_EICVector !== 6'd0 || bus.SI_Offset !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs int=%h vec=%h off=%h expected 0/0/0", bus.SI_Int, bus.SI_EICVector, bus.SI_Offset);
        end
        checks++;
        if (bus.SI_EICPresent !== 1'b1 || bus.SI_EISS !== 4'd0) begin
            failures++;
            $display("FAIL reset_consts present=%b eiss=%h expected 1/0", bus.SI_EICPresent, bus.SI_EISS);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.SI_EICVector !== 6'd0 || bus.SI_Offset !== 17'h100) begin
            failures++;
            $display("FAIL idle_after_reset vec=%h off=%h expected 0/100", bus.SI_EICVector, bus.SI_Offset);
        end
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reset_mask got=%h expected 0", rd);
        end
    endtask

    task automatic test_edge_iack();
        logic [31:0] rd;
        do_reset();
        reg_write(3'd0, 32'hFFFF_FFFF);
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0000_00FF) begin
            failures++;
            $display("FAIL mask_upper_bits got=%h expected 000000ff", rd);
        end
        reg_write(3'd1, 32'h01);
        irq[0] = 1'b1;
        tick(2);
        irq[0] = 1'b0;
        tick();
        checks++;
        if (bus.SI_EICVector !== 6'd0 || bus.SI_Offset !== 17'h100) begin
            failures++;
            $display("FAIL edge_too_early vec=%h off=%h expected 0/100", bus.SI_EICVector, bus.SI_Offset);
        end
        tick();
        checks++;
        if (bus.SI_Int !== 8'd1 || bus.SI_EICVector !== 6'd1 || bus.SI_Offset !== 17'h110) begin
            failures++;
            $display("FAIL edge_request int=%h vec=%h off=%h expected 1/1/110", bus.SI_Int, bus.SI_EICVector, bus.SI_Offset);
        end
        bus.SI_IAck = 1'b1;
        bus.SI_IVN  = 6'd0;
        tick();
        bus.SI_IVN  = 6'd2;
        tick();
        bus.SI_IAck = 1'b0;
        tick();
        checks++;
        if (bus.SI_EICVector !== 6'd1) begin
            failures++;
            $display("FAIL iack_mismatch_ignored vec=%h expected 1", bus.SI_EICVector);
        end
        bus.SI_IAck = 1'b1;
        bus.SI_IVN  = 6'd1;
        tick();
        bus.SI_IAck = 1'b0;
        tick();
        checks++;
        if (bus.SI_Int !== 8'd0 || bus.SI_EICVector !== 6'd0 || bus.SI_Offset !== 17'h100) begin
            failures++;
            $display("FAIL edge_acked int=%h vec=%h off=%h expected 0/0/100", bus.SI_Int, bus.SI_EICVector, bus.SI_Offset);
        end
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL edge_acked_pending got=%h expected 0", rd);
        end
    endtask

    task automatic test_level();
        logic [31:0] rd;
        do_reset();
        reg_write(3'd0, 32'hFF);
        irq = 8'h24;
        tick(2);
        reg_read(3'd3, rd);
        checks++;
        if (rd !== 32'h24) begin
            failures++;
            $display("FAIL raw_sync got=%h expected 24", rd);
        end
        tick(2);
        checks++;
        if (bus.SI_EICVector !== 6'd6 || bus.SI_Int !== 8'd6 || bus.SI_Offset !== 17'h160) begin
            failures++;
            $display("FAIL level_priority vec=%h int=%h off=%h expected 6/6/160", bus.SI_EICVector, bus.SI_Int, bus.SI_Offset);
        end
        bus.SI_IAck = 1'b1;
        bus.SI_IVN  = 6'd6;
        tick();
        bus.SI_IAck = 1'b0;
        checks++;
        if (bus.SI_EICVector !== 6'd6) begin
            failures++;
            $display("FAIL level_iack_edge vec=%h expected 6", bus.SI_EICVector);
        end
        tick();
        checks++;
        if (bus.SI_EICVector !== 6'd6) begin
            failures++;
            $display("FAIL level_iack_after vec=%h expected 6", bus.SI_EICVector);
        end
        irq = 8'h04;
        tick(3);
        checks++;
        if (bus.SI_EICVector !== 6'd6) begin
            failures++;
            $display("FAIL level_drop_early vec=%h expected 6", bus.SI_EICVector);
        end
        tick();
        checks++;
        if (bus.SI_EICVector !== 6'd3 || bus.SI_Offset !== 17'h130) begin
            failures++;
            $display("FAIL level_drop vec=%h off=%h expected 3/130", bus.SI_EICVector, bus.SI_Offset);
        end
        irq = 8'h00;
        tick(4);
    endtask

    task automatic test_mask();
        logic [31:0] rd;
        do_reset();
        reg_write(3'd0, 32'hFF);
        reg_write(3'd1, 32'h08);
        irq = 8'h08;
        tick(2);
        irq = 8'h00;
        tick(2);
        checks++;
        if (bus.SI_EICVector !== 6'd4 || bus.SI_Offset !== 17'h140) begin
            failures++;
            $display("FAIL mask_base vec=%h off=%h expected 4/140", bus.SI_EICVector, bus.SI_Offset);
        end
        reg_write(3'd0, 32'hF7);
        checks++;
        if (bus.SI_EICVector !== 6'd4) begin
            failures++;
            $display("FAIL mask_latency vec=%h expected 4", bus.SI_EICVector);
        end
        tick();
        checks++;
        if (bus.SI_EICVector !== 6'd0 || bus.SI_Int !== 8'd0 || bus.SI_Offset !== 17'h100) begin
            failures++;
            $display("FAIL masked vec=%h int=%h off=%h expected 0/0/100", bus.SI_EICVector, bus.SI_Int, bus.SI_Offset);
        end
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 32'h08) begin
            failures++;
            $display("FAIL masked_pending got=%h expected 08", rd);
        end
        reg_write(3'd0, 32'hFF);
        tick();
        checks++;
        if (bus.SI_EICVector !== 6'd4) begin
            failures++;
            $display("FAIL unmasked vec=%h expected 4", bus.SI_EICVector);
        end
    endtask

    task automatic test_edge_vs_clear();
        logic [31:0] rd;
        do_reset();
        reg_write(3'd1, 32'h02);
        irq[1] = 1'b1;
        tick(2);
        irq[1] = 1'b0;
        tick(4);
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 32'h02) begin
            failures++;
            $display("FAIL first_edge_pending got=%h expected 02", rd);
        end
        irq[1] = 1'b1;
        tick(2);
        reg_write(3'd2, 32'h02);
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 32'h02) begin
            failures++;
            $display("FAIL edge_beats_clear got=%h expected 02", rd);
        end
        reg_write(3'd2, 32'h02);
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL w1c_clear got=%h expected 0", rd);
        end
        irq[1] = 1'b0;
        tick(4);
    endtask

    task automatic test_reset_mid_request();
        logic [31:0] rd;
        do_reset();
        reg_write(3'd0, 32'hFF);
        reg_write(3'd1, 32'h81);
        irq = 8'h81;
        tick(2);
        irq = 8'h00;
        tick(2);
        checks++;
        if (bus.SI_EICVector !== 6'd8 || bus.SI_Offset !== 17'h180) begin
            failures++;
            $display("FAIL top_priority vec=%h off=%h expected 8/180", bus.SI_EICVector, bus.SI_Offset);
        end
        reg_read(3'd4, rd);
        checks++;
        if (rd !== 32'h8) begin
            failures++;
            $display("FAIL active_reg got=%h expected 8", rd);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.SI_Int !== 8'd0 || bus.SI_EICVector !== 6'd0 || bus.SI_Offset !== 17'h0) begin
            failures++;
            $display("FAIL reset_mid_req int=%h vec=%h off=%h expected 0/0/0", bus.SI_Int, bus.SI_EICVector, bus.SI_Offset);
        end
        rst = 1'b0;
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_mask got=%h expected 0", rd);
        end
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_pending got=%h expected 0", rd);
        end
        tick();
        checks++;
        if (bus.SI_EICVector !== 6'd0 || bus.SI_Offset !== 17'h100) begin
            failures++;
            $display("FAIL reset_mid_idle vec=%h off=%h expected 0/100", bus.SI_EICVector, bus.SI_Offset);
        end
        reg_write(3'd5, 32'hFFFF_FFFF);
        reg_read(3'd5, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reg5_read got=%h expected 0", rd);
        end
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reg5_write_ignored mask=%h expected 0", rd);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        irq           = 8'h00;
        bus.reg_addr  = 3'd0;
        bus.reg_we    = 1'b0;
        bus.reg_wdata = 32'h0;
        bus.SI_IAck   = 1'b0;
        bus.SI_IVN    = 6'd0;

        test_reset();
        test_edge_iack();
        test_level();
        test_mask();
        test_edge_vs_clear();
        test_reset_mid_request();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
